// File: rtl/gate_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// gate_bist_ctrl_if
// Bundle of signals between the BIST controller and the harness around one
// combinational gate-library netlist.
//
// Optional feature macro: GATE_BIST_STEP_EN (adds the 'step' signal).
//
// Signals:
//   start      harness -> ctrl  begin a run (honoured in IDLE or DONE)
//   golden     harness -> ctrl  expected signature, captured on entry to DONE
//   dut_out    netlist -> ctrl  combinational netlist response to dut_in
//   step       harness -> ctrl  (GATE_BIST_STEP_EN only) advance one pattern
//   dut_in     ctrl -> netlist  current pattern (bit0 = N1)
//   busy       ctrl -> harness  high in INIT and RUN
//   done       ctrl -> harness  high in DONE
//   pass       ctrl -> harness  signature matched golden, valid while done
//   signature  ctrl -> harness  live MISR contents
//   pat_cnt    ctrl -> harness  patterns folded so far
//
// Modports: master = harness side, slave = controller side.
// ---------------------------------------------------------------------------
interface gate_bist_ctrl_if #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 10,
  parameter int CNT_W = 16
);

  logic             start;
  logic [OUT_W-1:0] golden;
  logic [OUT_W-1:0] dut_out;
  logic [IN_W-1:0]  dut_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt;
`ifdef GATE_BIST_STEP_EN
  logic             step;
`endif

`ifdef GATE_BIST_STEP_EN
  modport master (
    output start, golden, dut_out, step,
    input  dut_in, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, golden, dut_out, step,
    output dut_in, busy, done, pass, signature, pat_cnt
  );
`else
  modport master (
    output start, golden, dut_out,
    input  dut_in, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, golden, dut_out,
    output dut_in, busy, done, pass, signature, pat_cnt
  );
`endif

endinterface

// File: rtl/gate_bist_ctrl.sv
// ---------------------------------------------------------------------------
// gate_bist_ctrl
// Built-in self-test controller for a combinational gate-library netlist.
// A 22-bit LFSR (x^22+x^21+1) drives the netlist inputs, the netlist outputs
// are compacted into a 10-bit MISR (x^10+x^7+1), and after NUM_PAT patterns
// the signature is compared against a golden value captured on entry to DONE.
//
// Optional feature macro: GATE_BIST_STEP_EN
//   defined   : bus.step gates LFSR/MISR/counter advance while in RUN
//   undefined : RUN advances every cycle
//
// Ports:
//   clk   clock, all state on rising edge
//   rst   asynchronous active-high reset
//   bus   gate_bist_ctrl_if.slave (start, golden, dut_out, [step] in;
//         dut_in, busy, done, pass, signature, pat_cnt out)
//
// Parameters: IN_W, OUT_W, CNT_W must match the interface instance.
//   NUM_PAT must lie in 1..2^CNT_W-1 (checked at elaboration).
//   The feedback taps are taken relative to the top of each register so the
//   default widths give exactly the polynomials above.
// ---------------------------------------------------------------------------
module gate_bist_ctrl #(
  parameter int              IN_W    = 22,
  parameter int              OUT_W   = 10,
  parameter int              CNT_W   = 16,
  parameter int              NUM_PAT = 256,
  parameter logic [IN_W-1:0] SEED    = {{(IN_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              rst,
  gate_bist_ctrl_if.slave   bus
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  generate
    if (NUM_PAT < 1 || longint'(NUM_PAT) > (longint'(1) << CNT_W) - 1) begin : g_bad_num_pat
      $error("gate_bist_ctrl: NUM_PAT must be in 1..2^CNT_W-1");
    end
    if (IN_W < 2 || OUT_W < 4) begin : g_bad_width
      $error("gate_bist_ctrl: IN_W must be >= 2 and OUT_W >= 4");
    end
  endgenerate

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
  localparam logic [IN_W-1:0]  SEED_EFF = (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  lfsr;
  logic [IN_W-1:0]  dut_in_q;
  logic [OUT_W-1:0] misr;
  logic [OUT_W-1:0] golden_q;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [IN_W-1:0]  lfsr_next;
  logic [OUT_W-1:0] misr_next;
  logic             adv;

  // Next LFSR / MISR values. dut_out is the netlist's response to the
  // pattern currently on dut_in, so it is folded in on the same edge.
  assign lfsr_next = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-2]};
  assign misr_next = {misr[OUT_W-2:0], misr[OUT_W-1] ^ misr[OUT_W-4]} ^ bus.dut_out;

`ifdef GATE_BIST_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Controller FSM with registered outputs. dut_in is kept as its own
  // register so it reads zero outside RUN while lfsr holds its value in DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      lfsr     <= SEED;
      dut_in_q <= '0;
      misr     <= '0;
      golden_q <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_INIT;
            busy_q <= 1'b1;
          end
        end

        S_INIT: begin
          lfsr     <= SEED_EFF;
          dut_in_q <= SEED_EFF;
          misr     <= '0;
          cnt      <= '0;
          state    <= S_RUN;
        end

        S_RUN: begin
          if (adv) begin
            lfsr <= lfsr_next;
            misr <= misr_next;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              // Last pattern folded on this edge: compare against the
              // golden value being captured so pass is valid with done.
              state    <= S_DONE;
              golden_q <= bus.golden;
              dut_in_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              pass_q   <= (misr_next == bus.golden);
            end else begin
              dut_in_q <= lfsr_next;
            end
          end
        end

        S_DONE: begin
          if (bus.start) begin
            state  <= S_INIT;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
          end else begin
            pass_q <= (misr == golden_q);
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr;
  assign bus.pat_cnt   = cnt;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gate_bist_ctrl
// Two controller instances (A: NUM_PAT=4, SEED=0; B: NUM_PAT=37, CNT_W=6)
// are checked every cycle against a pattern-index based reference model.
// Directed runs pin the model with hand-computed values, then randomized
// start/golden/dut_out (and step, if GATE_BIST_STEP_EN) traffic follows.
// ---------------------------------------------------------------------------
module tb_gate_bist_ctrl;

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_pass = 0;

  // Per-instance stimulus (index 0 = A, 1 = B)
  logic       start_v [2];
  logic [9:0] gold_v  [2];
  logic [9:0] mask_v  [2];
  logic       sel_v   [2];
`ifdef GATE_BIST_STEP_EN
  logic       step_v  [2];
`endif

  gate_bist_ctrl_if #(.IN_W(22), .OUT_W(10), .CNT_W(16)) ifa ();
  gate_bist_ctrl_if #(.IN_W(22), .OUT_W(10), .CNT_W(6))  ifb ();

  // Netlist stand-in: either a function of the applied pattern or a
  // constant/random mask, always combinational.
  assign ifa.start   = start_v[0];
  assign ifa.golden  = gold_v[0];
  assign ifa.dut_out = (sel_v[0] ? ifa.dut_in[9:0] : 10'h000) ^ mask_v[0];
  assign ifb.start   = start_v[1];
  assign ifb.golden  = gold_v[1];
  assign ifb.dut_out = (sel_v[1] ? ifb.dut_in[9:0] : 10'h000) ^ mask_v[1];
`ifdef GATE_BIST_STEP_EN
  assign ifa.step    = step_v[0];
  assign ifb.step    = step_v[1];
`endif

  gate_bist_ctrl #(.IN_W(22), .OUT_W(10), .CNT_W(16), .NUM_PAT(4), .SEED(22'h000000)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  gate_bist_ctrl #(.IN_W(22), .OUT_W(10), .CNT_W(6), .NUM_PAT(37), .SEED(22'h2A5F3C)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // -------------------------------------------------------------------------
  // Reference model: phase, number of patterns folded, signature, golden.
  // The pattern on dut_in is recomputed from the seed and the pattern index.
  // -------------------------------------------------------------------------
  localparam int PH_IDLE = 0, PH_INIT = 1, PH_RUN = 2, PH_DONE = 3;

  typedef struct {
    int         ph;
    int         cnt;
    logic [9:0] misr;
    logic [9:0] gq;
  } model_t;

  model_t m [2];

  function automatic logic [21:0] seed_of(input int i);
    return (i == 0) ? 22'h000001 : 22'h2A5F3C;
  endfunction

  function automatic int np_of(input int i);
    return (i == 0) ? 4 : 37;
  endfunction

  function automatic logic [21:0] pattern(input logic [21:0] s, input int k);
    logic [21:0] p;
    p = s;
    for (int j = 0; j < k; j++) p = {p[20:0], p[21] ^ p[20]};
    return p;
  endfunction

  function automatic logic [9:0] fold(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  function automatic logic [9:0] resp(input logic [21:0] p, input logic sel, input logic [9:0] mask);
    return (sel ? p[9:0] : 10'h000) ^ mask;
  endfunction

  function automatic model_t mstep(input model_t s, input int i, input logic start,
                                   input logic [9:0] gold, input logic adv,
                                   input logic sel, input logic [9:0] mask);
    model_t n;
    n = s;
    case (s.ph)
      PH_IDLE: if (start) n.ph = PH_INIT;
      PH_INIT: begin
        n.misr = 10'h000;
        n.cnt  = 0;
        n.ph   = PH_RUN;
      end
      PH_RUN: if (adv) begin
        n.misr = fold(s.misr) ^ resp(pattern(seed_of(i), s.cnt), sel, mask);
        n.cnt  = s.cnt + 1;
        if (s.cnt == np_of(i) - 1) begin
          n.gq = gold;
          n.ph = PH_DONE;
        end
      end
      default: if (start) n.ph = PH_INIT;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m[i] <= '{ph: PH_IDLE, cnt: 0, misr: 10'h000, gq: 10'h000};
      end else begin
`ifdef GATE_BIST_STEP_EN
        m[i] <= mstep(m[i], i, start_v[i], gold_v[i], step_v[i], sel_v[i], mask_v[i]);
`else
        m[i] <= mstep(m[i], i, start_v[i], gold_v[i], 1'b1, sel_v[i], mask_v[i]);
`endif
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Per-cycle compare against the model, on the falling edge.
  // -------------------------------------------------------------------------
  logic prev_done [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("dut_in", i, (i == 0) ? 32'(ifa.dut_in) : 32'(ifb.dut_in),
            (m[i].ph == PH_RUN) ? 32'(pattern(seed_of(i), m[i].cnt)) : 32'h0);
        chk("busy", i, (i == 0) ? 32'(ifa.busy) : 32'(ifb.busy),
            32'(m[i].ph == PH_INIT || m[i].ph == PH_RUN));
        chk("done", i, (i == 0) ? 32'(ifa.done) : 32'(ifb.done),
            32'(m[i].ph == PH_DONE));
        chk("pass", i, (i == 0) ? 32'(ifa.pass) : 32'(ifb.pass),
            32'(m[i].ph == PH_DONE && m[i].misr == m[i].gq));
        chk("signature", i, (i == 0) ? 32'(ifa.signature) : 32'(ifb.signature),
            32'(m[i].misr));
        chk("pat_cnt", i, (i == 0) ? 32'(ifa.pat_cnt) : 32'(ifb.pat_cnt),
            32'(m[i].cnt));
        if (m[i].ph == PH_DONE && !prev_done[i])
          $display("run inst%0d complete: signature=%03h golden=%03h match=%0b",
                   i, m[i].misr, m[i].gq, m[i].misr == m[i].gq);
        prev_done[i] <= (m[i].ph == PH_DONE);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int tied1 [3] = '{1, 3, 7};
  int seed0 [4] = '{1, 0, 4, 0};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      gold_v[i]  = 10'h000;
      mask_v[i]  = 10'h000;
      sel_v[i]   = 1'b0;
`ifdef GATE_BIST_STEP_EN
      step_v[i]  = 1'b1;
`endif
    end
    tick;
    tick;
    rst = 1'b0;
    tick;

    // Reset state
    chk("rst.busy", 0, 32'(ifa.busy), 32'h0);
    chk("rst.done", 0, 32'(ifa.done), 32'h0);
    chk("rst.dut_in", 0, 32'(ifa.dut_in), 32'h0);
    chk("rst.signature", 0, 32'(ifa.signature), 32'h0);
    chk("rst.pat_cnt", 1, 32'(ifb.pat_cnt), 32'h0);

    // A: outputs tied 0, SEED=0 overridden to 1 -> walking-one patterns
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("seq.dut_in", 0, 32'(ifa.dut_in), 32'h1 << k);
    end
    tick;
    chk("seq.done", 0, 32'(ifa.done), 32'h1);
    chk("seq.signature", 0, 32'(ifa.signature), 32'h0);
    chk("seq.pass", 0, 32'(ifa.pass), 32'h1);

    // A: outputs tied 001, golden 00F -> 001, 003, 007, 00F, pass
    mask_v[0] = 10'h001;
    gold_v[0] = 10'h00F;
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    tick;
    chk("tied1.clear_sig", 0, 32'(ifa.signature), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("tied1.signature", 0, 32'(ifa.signature), 32'(tied1[k]));
    end
    tick;
    chk("tied1.done", 0, 32'(ifa.done), 32'h1);
    chk("tied1.signature_final", 0, 32'(ifa.signature), 32'h00F);
    chk("tied1.pass", 0, 32'(ifa.pass), 32'h1);

    // A: rerun from DONE with golden 00E, start held through RUN -> pass=0
    gold_v[0] = 10'h00E;
    start_v[0] = 1'b1;
    tick;
    tick;
    chk("rerun.clear_sig", 0, 32'(ifa.signature), 32'h0);
    chk("rerun.clear_cnt", 0, 32'(ifa.pat_cnt), 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("rerun.pat_cnt", 0, 32'(ifa.pat_cnt), 32'(k));
    end
    start_v[0] = 1'b0;
    tick;
    chk("rerun.done", 0, 32'(ifa.done), 32'h1);
    chk("rerun.signature", 0, 32'(ifa.signature), 32'h00F);
    chk("rerun.pass", 0, 32'(ifa.pass), 32'h0);

    // A: dut_out = dut_in[9:0], seed override -> 001, 000, 004, 000
    mask_v[0] = 10'h000;
    sel_v[0]  = 1'b1;
    gold_v[0] = 10'h000;
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("seed0.signature", 0, 32'(ifa.signature), 32'(seed0[k]));
    end
    chk("seed0.done", 0, 32'(ifa.done), 32'h1);
    chk("seed0.pass", 0, 32'(ifa.pass), 32'h1);

    // B: reset at pat_cnt = 5 mid-RUN
    mask_v[1] = 10'h155;
    start_v[1] = 1'b1;
    tick;
    start_v[1] = 1'b0;
    tick;
    repeat (5) tick;
    chk("midrst.pat_cnt_before", 1, 32'(ifb.pat_cnt), 32'h5);
    chk("midrst.busy_before", 1, 32'(ifb.busy), 32'h1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.busy", 1, 32'(ifb.busy), 32'h0);
    chk("midrst.done", 1, 32'(ifb.done), 32'h0);
    chk("midrst.dut_in", 1, 32'(ifb.dut_in), 32'h0);
    chk("midrst.signature", 1, 32'(ifb.signature), 32'h0);
    chk("midrst.pat_cnt", 1, 32'(ifb.pat_cnt), 32'h0);
    tick;

    // Randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        start_v[i] = ($urandom_range(0, 11) == 0);
        sel_v[i]   = 1'($urandom_range(0, 1));
        mask_v[i]  = 10'($urandom);
`ifdef GATE_BIST_STEP_EN
        step_v[i]  = ($urandom_range(0, 2) != 0);
`endif
        // Half the time offer the signature the run would reach if this
        // were its last pattern, so both pass outcomes occur.
        if ($urandom_range(0, 1) == 1)
          gold_v[i] = fold(m[i].misr) ^ resp(pattern(seed_of(i), m[i].cnt), sel_v[i], mask_v[i]);
        else
          gold_v[i] = 10'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
